branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//   Dynamic branch predictor for the pipelined RV32I core's Fetch stage. Direct-mapped branch
//   target buffer (BTB) with per-entry saturating counters. Fetch uses it to pick the next PC in the
//   same cycle, so a correctly predicted taken branch or jump no longer costs a two-stage flush.
//   Execute feeds back resolved outcomes to train the table.
// PARAMETERS
//   ADDR_WIDTH     32  PC width
//   ENTRIES        64  BTB entries; power of 2, >= 2; IDX_W = log2(ENTRIES)
//   TAG_WIDTH      10  tag bits stored per entry
//   COUNTER_WIDTH   2  saturating counter width, >= 1
// PORTS
//   clk              in   1           clock, rising edge
//   rst              in   1           asynchronous reset, active-low (0 = reset)
//   lookup_valid     in   1           Fetch lookup qualifier (statistics only)
//   lookup_pc        in   ADDR_WIDTH  PC currently in Fetch
//   pred_taken       out  1           predicted redirect
//   pred_next_pc     out  ADDR_WIDTH  predicted next PC
//   clear            in   1           invalidate whole table (e.g. fence.i)
//   upd_valid        in   1           Execute has a resolved branch/jump this cycle
//   upd_pc           in   ADDR_WIDTH  PC of the resolved instruction
//   upd_taken        in   1           actual outcome
//   upd_is_jump      in   1           jal/jalr (always taken)
//   upd_target       in   ADDR_WIDTH  actual target
//   upd_mispredict   in   1           Execute detected misprediction (statistics only)
//   stat_lookups     out  32          lookups counted
//   stat_hits        out  32          lookups that hit
//   stat_mispredicts out  32          mispredictions reported
// BEHAVIOUR
//   - Index = pc[IDX_W+1:2]; tag = pc[IDX_W+2 +: TAG_WIDTH]. Entry = {valid, tag, target, jump, ctr}.
//   - Lookup is combinational, zero latency: hit = valid && tag match.
//     pred_taken = hit && (jump || ctr MSB). pred_next_pc = pred_taken ? target : lookup_pc + 4
//     (modulo 2^ADDR_WIDTH, wraps).
//   - Update commits at the posedge with upd_valid=1.
//     Hit: ctr +1 if upd_taken, else -1; saturates at 0 and 2^CW-1. Target and jump are rewritten
//     when upd_taken.
//     Miss, taken: allocate or overwrite the entry. valid=1, tag, target, jump=upd_is_jump.
//     ctr = 2^CW-1 for a jump, else 2^(CW-1) (weakly taken).
//     Miss, not taken: no change; not-taken branches never allocate.
//   - Same-cycle lookup and update to the same index: the lookup sees the pre-update entry.
//     No write-through bypass.
//   - clear: synchronous. All valid bits go to 0 at the next edge and counters go to 2^(CW-1)-1.
//     If clear and upd_valid arrive in the same cycle, clear wins and the update is dropped.
//   - Reset (rst=0, asynchronous, any time including mid-update):
//     all valid=0, ctr=2^(CW-1)-1, stat counters=0.
//     Outputs during reset: pred_taken=0, pred_next_pc=lookup_pc+4.
//     First update is accepted on the first posedge after rst deasserts.
//   - Targets are stored in full. jalr targets are trained like jal. No return-address stack.
// CONFIGURATION
//   BP_STATS_EN defined:
//     - stat_lookups increments on each edge with lookup_valid.
//     - stat_hits increments on each edge with lookup_valid && hit.
//     - stat_mispredicts increments on each edge with upd_valid && upd_mispredict.
//     - All three saturate at 32'hFFFF_FFFF. Cleared by reset only, not by clear.
//   BP_STATS_EN undefined: the ports exist, are tied to 32'h0, and no counter flops are built.
// TESTING
//   1. Reset, lookup 0x0000_0100 -> pred_taken=0, pred_next_pc=0x0000_0104.
//   2. Update pc=0x100, taken, target=0x80 -> next cycle, lookup 0x100 gives pred_taken=1,
//      pred_next_pc=0x80.
//   3. Same entry, two not-taken updates -> ctr 10->01->00, pred_taken=0. Then three taken
//      updates -> ctr saturates at 11.
//   4. Aliasing: train 0x100 taken, then lookup 0x100+4*ENTRIES (same index, different tag)
//      -> miss, pred_next_pc=pc+4.
//   5. jal at 0x200, target 0x400 -> ctr=11; one not-taken update has no effect on prediction
//      (jump bit).
//   6. clear together with upd_valid -> all lookups miss. With BP_STATS_EN: 3 lookups, 1 hit and
//      1 mispredict are reported as 3/1/1.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating counters.
// Zero-latency lookup for Fetch and training from resolved outcomes in Execute.
// Optional statistics counters are built only when BP_STATS_EN is defined;
// otherwise the stat_* ports are tied to zero.
module branch_predictor #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ENTRIES       = 64,
    parameter int TAG_WIDTH     = 10,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_next_pc,
    input  logic                  clear,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic                  upd_is_jump,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_mispredict,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CW    = COUNTER_WIDTH;

    // Counter landmarks: saturated taken, weakly taken (fresh branch), weakly not-taken (reset/clear).
    localparam logic [CW-1:0] CTR_MAX  = '1;
    localparam logic [CW-1:0] CTR_WT   = CW'(1) << (CW - 1);
    localparam logic [CW-1:0] CTR_WNT  = CTR_WT - CW'(1);

    // Table storage: valid and counters are reset; payload fields are qualified by valid.
    logic [ENTRIES-1:0]          validQ;
    logic [ENTRIES-1:0][CW-1:0]  ctrQ;
    logic [TAG_WIDTH-1:0]        tagQ    [ENTRIES];
    logic [ADDR_WIDTH-1:0]       targetQ [ENTRIES];
    logic                        jumpQ   [ENTRIES];

    logic [IDX_W-1:0]     lookupIdx;
    logic [TAG_WIDTH-1:0] lookupTag;
    logic                 lookupHit;

    logic [IDX_W-1:0]     updIdx;
    logic [TAG_WIDTH-1:0] updTag;
    logic                 updHit;
    logic                 updWriteInfo;
    logic                 updWriteCtr;
    logic [CW-1:0]        ctrNext;

    assign lookupIdx = lookup_pc[IDX_W+1:2];
    assign lookupTag = lookup_pc[IDX_W+2 +: TAG_WIDTH];
    assign updIdx    = upd_pc[IDX_W+1:2];
    assign updTag    = upd_pc[IDX_W+2 +: TAG_WIDTH];

    // Lookup: combinational read of the pre-update entry, gated while reset is asserted.
    always_comb begin
        lookupHit    = rst && validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
        pred_taken   = lookupHit && (jumpQ[lookupIdx] || ctrQ[lookupIdx][CW-1]);
        pred_next_pc = pred_taken ? targetQ[lookupIdx] : lookup_pc + ADDR_WIDTH'(4);
    end

    // Update decode: hit trains the counter, any taken outcome (re)writes the entry payload.
    always_comb begin
        updHit       = validQ[updIdx] && (tagQ[updIdx] == updTag);
        updWriteInfo = upd_valid && upd_taken;
        updWriteCtr  = upd_valid && (updHit || upd_taken);
        ctrNext      = ctrQ[updIdx];
        if (updHit) begin
            if (upd_taken && (ctrQ[updIdx] != CTR_MAX)) begin
                ctrNext = ctrQ[updIdx] + CW'(1);
            end else if (!upd_taken && (ctrQ[updIdx] != '0)) begin
                ctrNext = ctrQ[updIdx] - CW'(1);
            end
        end else if (upd_taken) begin
            ctrNext = upd_is_jump ? CTR_MAX : CTR_WT;
        end
    end

    // Valid bits and counters: async reset, synchronous clear beats any same-cycle update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validQ <= '0;
            ctrQ   <= {ENTRIES{CTR_WNT}};
        end else if (clear) begin
            validQ <= '0;
            ctrQ   <= {ENTRIES{CTR_WNT}};
        end else begin
            if (updWriteInfo) begin
                validQ[updIdx] <= 1'b1;
            end
            if (updWriteCtr) begin
                ctrQ[updIdx] <= ctrNext;
            end
        end
    end

    // Payload (tag, target, jump): no reset; writes suppressed under reset and clear so they
    // track exactly the updates the valid/counter block accepts.
    always_ff @(posedge clk) begin
        if (rst && !clear && updWriteInfo) begin
            tagQ[updIdx]    <= updTag;
            targetQ[updIdx] <= upd_target;
            jumpQ[updIdx]   <= upd_is_jump;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] statLookupsQ;
    logic [31:0] statHitsQ;
    logic [31:0] statMispredictsQ;

    // Saturating event counters; cleared by reset only, unaffected by table clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statLookupsQ     <= '0;
            statHitsQ        <= '0;
            statMispredictsQ <= '0;
        end else begin
            if (lookup_valid && (statLookupsQ != '1)) begin
                statLookupsQ <= statLookupsQ + 32'd1;
            end
            if (lookup_valid && lookupHit && (statHitsQ != '1)) begin
                statHitsQ <= statHitsQ + 32'd1;
            end
            if (upd_valid && upd_mispredict && (statMispredictsQ != '1)) begin
                statMispredictsQ <= statMispredictsQ + 32'd1;
            end
        end
    end

    assign stat_lookups     = statLookupsQ;
    assign stat_hits        = statHitsQ;
    assign stat_mispredicts = statMispredictsQ;

    logic unusedPcBits;
    assign unusedPcBits = ^{lookup_pc, upd_pc};
`else
    assign stat_lookups     = '0;
    assign stat_hits        = '0;
    assign stat_mispredicts = '0;

    logic unusedStatInputs;
    assign unusedStatInputs = ^{lookup_valid, upd_mispredict, lookup_pc, upd_pc};
`endif

endmodule
